regfile_wb_arbiter: RTL and testbench

Write-back arbiter and hazard scoreboard for the single-write-port register file. It merges the ALU (fixed-latency) and LSU (variable-latency load return) write-back streams onto one registered write port (`rf_wen`/`rf_rd`/`rf_wdata`). It tracks destination registers of outstanding loads and unretired ALU writes, and tells the issue stage when an instruction may issue without a RAW or WAW hazard. It sits between the execute/LSU stages and the register file write port.

---
 rtl/regfile_wb_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the single register-file write port, with a deferred ALU write queue
// and a load scoreboard that gates instruction issue on RAW/WAW hazards.
module regfile_wb_arbiter #(
  parameter int unsigned DW     = 64,
  parameter int unsigned QDEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue_valid,
  input  logic          issue_is_load,
  input  logic [4:0]    issue_rd,
  input  logic [4:0]    issue_rs1,
  input  logic [4:0]    issue_rs2,
  output logic          issue_ready,
  input  logic          alu_valid,
  input  logic [4:0]    alu_rd,
  input  logic [DW-1:0] alu_data,
  input  logic          lsu_valid,
  input  logic [4:0]    lsu_rd,
  input  logic [DW-1:0] lsu_data,
  output logic          rf_wen,
  output logic [4:0]    rf_rd,
  output logic [DW-1:0] rf_wdata,
  output logic [31:0]   busy,
  output logic          err
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  logic          r_rf_wen;
  logic [4:0]    r_rf_rd;
  logic [DW-1:0] r_rf_wdata;
  logic [31:0]   r_busy;
  logic          r_err;

  logic [4:0]    r_q_rd   [QDEPTH];
  logic [DW-1:0] r_q_data [QDEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic              w_q_empty;
  logic              w_q_full;
  logic              w_q_nearfull;
  logic [QDEPTH-1:0] w_q_vld;
  logic              w_sel_lsu;
  logic              w_sel_q;
  logic              w_sel_alu;
  logic              w_pop;
  logic              w_push_req;
  logic              w_push;
  logic              w_wen;
  logic [4:0]        w_wr_rd;
  logic [DW-1:0]     w_wr_data;
  logic              w_err_set;
  logic              w_sb_set;
  logic [31:0]       w_busy_d;
  logic [2:0][4:0]   w_src;
  logic              w_hazard;

  assign w_q_empty    = (r_count == '0);
  assign w_q_full     = (r_count == CW'(QDEPTH));
  assign w_q_nearfull = (r_count >= CW'(QDEPTH - 1));

  // Entry k is live when its distance from the read pointer is below the count.
  always_comb begin
    w_q_vld = '0;
    for (int k = 0; k < QDEPTH; k++) begin
      w_q_vld[k] = (CW'(PW'(PW'(k) - r_rd_ptr)) < r_count);
    end
  end

  assign w_sel_lsu = lsu_valid;
  assign w_sel_q   = !lsu_valid && !w_q_empty;
  assign w_sel_alu = !lsu_valid && w_q_empty && alu_valid;
  assign w_pop     = w_sel_q;

  // Any ALU result that misses the port is queued so ALU writes retire in order.
  assign w_push_req = alu_valid && (alu_rd != 5'd0) && !w_sel_alu;
  assign w_push     = w_push_req && (!w_q_full || w_pop);

  always_comb begin
    w_wen     = 1'b0;
    w_wr_rd   = 5'd0;
    w_wr_data = '0;
    if (w_sel_lsu) begin
      w_wen     = (lsu_rd != 5'd0);
      w_wr_rd   = lsu_rd;
      w_wr_data = lsu_data;
    end else if (w_sel_q) begin
      w_wen     = 1'b1;
      w_wr_rd   = r_q_rd[r_rd_ptr];
      w_wr_data = r_q_data[r_rd_ptr];
    end else if (w_sel_alu) begin
      w_wen     = (alu_rd != 5'd0);
      w_wr_rd   = alu_rd;
      w_wr_data = alu_data;
    end
  end

  assign w_err_set = (lsu_valid && (lsu_rd != 5'd0) && !r_busy[lsu_rd]) ||
                     (w_push_req && !w_push) ||
                     (alu_valid && lsu_valid && w_q_full);

  assign w_sb_set = issue_valid && issue_ready && issue_is_load && (issue_rd != 5'd0);

  // Clear before set so a same-index return and reissue leaves the bit set.
  always_comb begin
    w_busy_d = r_busy;
    if (lsu_valid) begin
      w_busy_d[lsu_rd] = 1'b0;
    end
    if (w_sb_set) begin
      w_busy_d[issue_rd] = 1'b1;
    end
    w_busy_d[0] = 1'b0;
  end

  assign w_src = {issue_rd, issue_rs2, issue_rs1};

  always_comb begin
    w_hazard = 1'b0;
    for (int j = 0; j < 3; j++) begin
      if (w_src[j] != 5'd0) begin
        if (r_busy[w_src[j]]) begin
          w_hazard = 1'b1;
        end
        if (r_rf_wen && (r_rf_rd == w_src[j])) begin
          w_hazard = 1'b1;
        end
        if (alu_valid && (alu_rd == w_src[j])) begin
          w_hazard = 1'b1;
        end
        for (int k = 0; k < QDEPTH; k++) begin
          if (w_q_vld[k] && (r_q_rd[k] == w_src[j])) begin
            w_hazard = 1'b1;
          end
        end
      end
    end
  end

  // Near-full leaves one slot for an ALU result already in flight.
  assign issue_ready = !w_q_nearfull && !w_hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rf_wen   <= 1'b0;
      r_rf_rd    <= 5'd0;
      r_rf_wdata <= '0;
      r_busy     <= '0;
      r_err      <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      for (int k = 0; k < QDEPTH; k++) begin
        r_q_rd[k]   <= 5'd0;
        r_q_data[k] <= '0;
      end
    end else begin
      r_rf_wen <= w_wen;
      if (w_wen) begin
        r_rf_rd    <= w_wr_rd;
        r_rf_wdata <= w_wr_data;
      end
      r_busy <= w_busy_d;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      if (w_push) begin
        r_q_rd[r_wr_ptr]   <= alu_rd;
        r_q_data[r_wr_ptr] <= alu_data;
        r_wr_ptr           <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  assign rf_wen   = r_rf_wen;
  assign rf_rd    = r_rf_rd;
  assign rf_wdata = r_rf_wdata;
  assign busy     = r_busy;
  assign err      = r_err;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus random traffic, all checked against a
// queue-based reference model of the write-back and scoreboard rules.
module tb_regfile_wb_arbiter;

  localparam int unsigned DW     = 64;
  localparam int unsigned QDEPTH = 2;

  logic          clk;
  logic          rst;
  logic          issue_valid;
  logic          issue_is_load;
  logic [4:0]    issue_rd;
  logic [4:0]    issue_rs1;
  logic [4:0]    issue_rs2;
  logic          issue_ready;
  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [DW-1:0] alu_data;
  logic          lsu_valid;
  logic [4:0]    lsu_rd;
  logic [DW-1:0] lsu_data;
  logic          rf_wen;
  logic [4:0]    rf_rd;
  logic [DW-1:0] rf_wdata;
  logic [31:0]   busy;
  logic          err;

  regfile_wb_arbiter #(
    .DW     (DW),
    .QDEPTH (QDEPTH)
  ) u_dut (
    .clk           (clk),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_is_load (issue_is_load),
    .issue_rd      (issue_rd),
    .issue_rs1     (issue_rs1),
    .issue_rs2     (issue_rs2),
    .issue_ready   (issue_ready),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .lsu_valid     (lsu_valid),
    .lsu_rd        (lsu_rd),
    .lsu_data      (lsu_data),
    .rf_wen        (rf_wen),
    .rf_rd         (rf_rd),
    .rf_wdata      (rf_wdata),
    .busy          (busy),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model state
  typedef struct {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           m_q[$];
  bit [31:0]     m_busy;
  bit            m_wen;
  logic [4:0]    m_rd;
  logic [DW-1:0] m_wdata;
  bit            m_err;

  function automatic bit model_ready(input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [4:0] rd, input logic av, input logic [4:0] ard);
    logic [4:0] idx [3];
    if (m_q.size() >= QDEPTH - 1) return 1'b0;
    idx = '{rs1, rs2, rd};
    foreach (idx[j]) begin
      if (idx[j] != 0) begin
        if (m_busy[idx[j]]) return 1'b0;
        if (m_wen && m_rd == idx[j]) return 1'b0;
        if (av && ard == idx[j]) return 1'b0;
        foreach (m_q[k]) if (m_q[k].rd == idx[j]) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  task automatic model_clear();
    m_q.delete();
    m_busy  = '0;
    m_wen   = 1'b0;
    m_rd    = '0;
    m_wdata = '0;
    m_err   = 1'b0;
  endtask

  task automatic drive_idle();
    issue_valid = 0; issue_is_load = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
    alu_valid = 0; alu_rd = 0; alu_data = '0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = '0;
  endtask

  // One clock cycle: drive, check combinational ready, advance model, check registered state.
  task automatic step(input logic iv, input logic il, input logic [4:0] ird,
                      input logic [4:0] irs1, input logic [4:0] irs2,
                      input logic av, input logic [4:0] ard, input logic [DW-1:0] ad,
                      input logic lv, input logic [4:0] lrd, input logic [DW-1:0] ld);
    bit            rdy;
    bit            was_full;
    bit            direct;
    bit            n_wen;
    logic [4:0]    n_rd;
    logic [DW-1:0] n_d;
    wr_t           e;
    @(negedge clk);
    issue_valid = iv; issue_is_load = il; issue_rd = ird; issue_rs1 = irs1; issue_rs2 = irs2;
    alu_valid = av; alu_rd = ard; alu_data = ad;
    lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
    #1;
    rdy = model_ready(irs1, irs2, ird, av, ard);
    check_eq("issue_ready", issue_ready, rdy);

    was_full = (m_q.size() == QDEPTH);
    direct   = 1'b0;
    n_wen    = 1'b0;
    n_rd     = '0;
    n_d      = '0;
    if (lv) begin
      n_wen = (lrd != 0); n_rd = lrd; n_d = ld;
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      n_wen = 1'b1; n_rd = e.rd; n_d = e.data;
    end else if (av) begin
      direct = 1'b1;
      n_wen = (ard != 0); n_rd = ard; n_d = ad;
    end
    if (av && ard != 0 && !direct) begin
      if (m_q.size() < QDEPTH) m_q.push_back('{rd: ard, data: ad});
      else m_err = 1'b1;
    end
    if (av && lv && was_full) m_err = 1'b1;
    if (lv && lrd != 0 && !m_busy[lrd]) m_err = 1'b1;
    if (lv) m_busy[lrd] = 1'b0;
    if (iv && rdy && il && ird != 0) m_busy[ird] = 1'b1;
    m_busy[0] = 1'b0;
    m_wen = n_wen;
    if (n_wen) begin
      m_rd = n_rd; m_wdata = n_d;
    end

    @(posedge clk);
    #1;
    check_eq("rf_wen", rf_wen, m_wen);
    if (m_wen) begin
      check_eq("rf_rd", rf_rd, m_rd);
      check_eq("rf_wdata", rf_wdata, m_wdata);
    end
    check_eq("busy", busy, m_busy);
    check_eq("err", err, m_err);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, '0, 0, 0, '0);
  endtask

  // Asynchronous reset with rs1=5 presented; everything must read as reset immediately.
  task automatic apply_reset();
    @(negedge clk);
    drive_idle();
    issue_valid = 1; issue_rs1 = 5;
    rst = 1'b0;
    #1;
    check_eq("rst_rf_wen", rf_wen, 0);
    check_eq("rst_rf_rd", rf_rd, 0);
    check_eq("rst_rf_wdata", rf_wdata, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_ready", issue_ready, 1);
    model_clear();
    @(negedge clk);
    drive_idle();
    rst = 1'b1;
  endtask

  function automatic logic [4:0] pick_busy();
    logic [4:0] cand[$];
    for (int i = 1; i < 32; i++) if (m_busy[i]) cand.push_back(5'(i));
    if (cand.size() == 0) return 5'd0;
    return cand[$urandom_range(cand.size() - 1)];
  endfunction

  initial begin
    logic          iv, il, av, lv;
    logic [4:0]    ird, irs1, irs2, ard, lrd;
    logic [DW-1:0] ad, ld;

    drive_idle();
    rst = 1'b0;
    model_clear();
    apply_reset();

    // ALU only: three back-to-back results, no queueing
    step(0, 0, 0, 0, 0, 1, 3, 64'hAA, 0, 0, '0);
    check_eq("alu_first_rd", rf_rd, 3);
    step(0, 0, 0, 0, 0, 1, 3, 64'hAA, 0, 0, '0);
    step(0, 0, 0, 0, 0, 1, 3, 64'hAA, 0, 0, '0);
    idle(1);
    check_eq("alu_done", rf_wen, 0);

    // Collision: LSU wins, ALU deferred one cycle; rs1=8 stalls meanwhile
    step(1, 1, 7, 0, 0, 0, 0, '0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 1, 8, 64'h22, 1, 7, 64'h11);
    check_eq("coll_lsu_rd", rf_rd, 7);
    step(1, 0, 0, 8, 0, 0, 0, '0, 0, 0, '0);
    check_eq("coll_alu_rd", rf_rd, 8);
    check_eq("coll_alu_data", rf_wdata, 64'h22);
    idle(1);

    // Load hazard on x10
    step(1, 1, 10, 0, 0, 0, 0, '0, 0, 0, '0);
    check_eq("ld_busy10", busy[10], 1);
    step(1, 0, 0, 0, 10, 0, 0, '0, 0, 0, '0);
    step(1, 0, 0, 0, 10, 0, 0, '0, 1, 10, 64'h55);
    check_eq("ld_wr_rd", rf_rd, 10);
    step(1, 0, 0, 0, 10, 0, 0, '0, 0, 0, '0);
    step(1, 0, 0, 0, 10, 0, 0, '0, 0, 0, '0);

    // x0 handling
    step(1, 1, 0, 0, 0, 1, 0, 64'h99, 0, 0, '0);
    check_eq("x0_wen", rf_wen, 0);
    check_eq("x0_busy", busy, 0);
    idle(1);

    // Unexpected load return: error, but write still happens
    step(0, 0, 0, 0, 0, 0, 0, '0, 1, 4, 64'h44);
    check_eq("err_unexp", err, 1);
    check_eq("err_unexp_rd", rf_rd, 4);
    apply_reset();

    // Queue fill and overflow under continuous LSU returns
    step(1, 1, 20, 0, 0, 0, 0, '0, 0, 0, '0);
    step(1, 1, 21, 0, 0, 0, 0, '0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 1, 12, 64'h12, 1, 20, 64'h20);
    step(1, 0, 0, 1, 0, 1, 13, 64'h13, 1, 21, 64'h21);
    check_eq("fill_no_err", err, 0);
    step(0, 0, 0, 0, 0, 1, 14, 64'h14, 1, 0, '0);
    check_eq("ovf_err", err, 1);
    idle(3);

    // Reset mid-stream with one queued entry and busy[5]
    apply_reset();
    step(1, 1, 5, 0, 0, 0, 0, '0, 0, 0, '0);
    step(0, 0, 0, 0, 0, 1, 9, 64'h9, 1, 0, '0);
    apply_reset();
    step(1, 0, 0, 5, 0, 0, 0, '0, 0, 0, '0);
    idle(2);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      if (n % 700 == 699) apply_reset();
      iv   = ($urandom_range(1) == 1);
      il   = ($urandom_range(1) == 1);
      ird  = 5'($urandom_range(15));
      irs1 = 5'($urandom_range(15));
      irs2 = 5'($urandom_range(15));
      av   = ($urandom_range(99) < 40);
      ard  = 5'($urandom_range(15));
      ad   = {$urandom, $urandom};
      ld   = {$urandom, $urandom};
      lv   = 1'b0;
      lrd  = '0;
      if (m_busy != 0 && $urandom_range(99) < 35) begin
        lv = 1'b1; lrd = pick_busy();
      end else if ($urandom_range(99) < 3) begin
        lv = 1'b1; lrd = 5'($urandom_range(31));
      end
      step(iv, il, ird, irs1, irs2, av, ard, ad, lv, lrd, ld);
    end
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
